dram_writer: RTL
================

DRAM_WRITER -- requirements
Module: dram_writer

Interface
REQ-001 Parameters: none; all burst constants SHALL come from the shared package.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 fclk  in  1  sole clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 M2S_AXI_ACLK  out  1  driven equal to fclk.
REQ-006 M2S_AXI_AWVALID/AWREADY  out/in  1/1  write-address handshake.
REQ-007 M2S_AXI_AWADDR  out  32  burst start address.
REQ-008 M2S_AXI_AWBURST/AWLEN/AWSIZE  out  2/4/2  constants 2'b01 (INCR), 4'b1111 (16 beats), 2'b11 (8 bytes/beat).
REQ-009 M2S_AXI_WVALID/WREADY/WLAST  out/in/out  1/1/1  write-data handshake and last-beat flag.
REQ-010 M2S_AXI_WDATA, M2S_AXI_WSTRB  out  64, 8  data; WSTRB constant 8'hFF.
REQ-011 M2S_AXI_BVALID/BREADY, M2S_AXI_BRESP  in/out, in  1/1, 2  write response.
REQ-012 wr_frame_valid/wr_frame_ready  in/out  1/1  frame-config handshake.
REQ-013 wr_BUF_ADDR, wr_FRAME_BYTES  in  32, 32  frame base address and byte length.
REQ-014 wr_frame_done  out  1  one-cycle pulse when the final burst response is accepted.
REQ-015 wr_error  out  1  sticky flag: any BRESP != 2'b00 since the last config accept.
REQ-016 din_burst_valid  in  1  upstream buffer holds at least 16 words.
REQ-017 din_valid/din_ready, din  in/out, in  1/1, 64  data stream.
REQ-018 debug_astate  out  2  current state encoding.

Function
REQ-019 States SHALL be IDLE=0, FRAME_IDLE=1, ADDR=2, DATA_RESP=3; one transaction in flight at a time.
REQ-020 IDLE: wr_frame_ready=1. On wr_frame_valid, latch AWADDR<=wr_BUF_ADDR, bursts_left<=max(1, wr_FRAME_BYTES>>7), clear wr_error, go to FRAME_IDLE. wr_FRAME_BYTES[6:0] is ignored.
REQ-021 FRAME_IDLE: when din_burst_valid=1, assert AWVALID the next cycle and go to ADDR.
REQ-022 ADDR: hold AWVALID and AWADDR stable until AWREADY=1. On that cycle, deassert AWVALID, load beat_cnt<=15, and go to DATA_RESP.
REQ-023 DATA_RESP data phase: WVALID=din_valid, din_ready=WREADY, WDATA=din (combinational). WLAST=1 when beat_cnt==0 and the data phase is active. Each transfer (WVALID&&WREADY) decrements beat_cnt.
REQ-024 After the last-beat transfer, the data phase ends: WVALID and din_ready are forced to 0, and BREADY=1 until BVALID.
REQ-025 On BVALID&&BREADY:
- set wr_error if BRESP!=0;
- AWADDR += 128 (32-bit wrap);
- bursts_left -= 1.
If bursts_left was 1, pulse wr_frame_done and go to IDLE; otherwise go to FRAME_IDLE.
REQ-026 din_ready SHALL be 0 outside the DATA_RESP data phase. No data is consumed before the address handshake completes.
REQ-027 Address wrap past 32'hFFFF_FFFF SHALL wrap silently; no 4 KB boundary checking (caller aligns BUF_ADDR to 128).
REQ-028 wr_frame_valid outside IDLE SHALL be ignored (wr_frame_ready=0).

Reset
REQ-029 On rst_n=0, immediately: state=IDLE, AWVALID=0, AWADDR=0, bursts_left=0, beat_cnt=0, wr_frame_done=0, wr_error=0. Combinationally: din_ready=0, WVALID=0, BREADY=0. wr_frame_ready=1 in IDLE.
REQ-030 Reset mid-burst SHALL abandon the AXI transaction without completing it. System reset of the interconnect is the caller's duty.

Structure
REQ-031 The shared package dram_pkg SHALL hold: BURST_BEATS=16, BURST_BYTES=128, AXI_LEN/SIZE/BURST constants, and the state enum shared with the read engine.
REQ-032 No sub-module; a single always block for state/counters plus continuous assigns.

Verification
REQ-033 Config BUF_ADDR=32'h1000_0000, FRAME_BYTES=256, din_burst_valid=1, slave always ready, BRESP=0 -> AWADDR 1000_0000 then 1000_0080; 32 beats; WLAST on beats 16 and 32; one wr_frame_done pulse; wr_error=0.
REQ-034 AWREADY low 5 cycles -> AWVALID and AWADDR held stable; din_ready=0 throughout.
REQ-035 WREADY toggling and din_valid gaps -> exactly 16 transfers per burst; WDATA order matches din order; WLAST only with the 16th transfer.
REQ-036 BRESP=2'b10 on burst 1 of 2 -> wr_error=1 and remains set through wr_frame_done; cleared by the next config accept.
REQ-037 FRAME_BYTES=0 -> one burst written; BUF_ADDR=32'hFFFF_FF80 with FRAME_BYTES=256 -> second AWADDR=0.
REQ-038 rst_n asserted at beat 7 -> all outputs at reset values the same cycle; new config after release completes normally.

Source files
------------

// File: rtl/dram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dram_pkg
// Description : Burst geometry, AXI constants and engine state encoding
//               shared by the DRAM read and write engines.
// Revision    : 1.0 - initial release
// ============================================================================
package dram_pkg;

    localparam int BURST_BEATS = 16;
    localparam int BURST_BYTES = 128;
    localparam int BURST_SHIFT = 7;

    localparam logic [3:0] AXI_LEN   = 4'(BURST_BEATS - 1);
    localparam logic [1:0] AXI_SIZE  = 2'b11;
    localparam logic [1:0] AXI_BURST = 2'b01;
    localparam logic [7:0] AXI_WSTRB = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_FRAME_IDLE = 2'd1,
        ST_ADDR       = 2'd2,
        ST_DATA_RESP  = 2'd3
    } dram_state_e;

endpackage
`default_nettype wire

// File: rtl/dram_writer.sv
`default_nettype none
// ============================================================================
// Module      : dram_writer
// Description : Streams a frame from an upstream FIFO into DRAM as a series
//               of 16-beat, 64-bit AXI INCR write bursts, one in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_writer
    import dram_pkg::*;
(
    input  logic        fclk,
    input  logic        rst_n,

    output logic        M2S_AXI_ACLK,
    output logic        M2S_AXI_AWVALID,
    input  logic        M2S_AXI_AWREADY,
    output logic [31:0] M2S_AXI_AWADDR,
    output logic [1:0]  M2S_AXI_AWBURST,
    output logic [3:0]  M2S_AXI_AWLEN,
    output logic [1:0]  M2S_AXI_AWSIZE,
    output logic        M2S_AXI_WVALID,
    input  logic        M2S_AXI_WREADY,
    output logic        M2S_AXI_WLAST,
    output logic [63:0] M2S_AXI_WDATA,
    output logic [7:0]  M2S_AXI_WSTRB,
    input  logic        M2S_AXI_BVALID,
    output logic        M2S_AXI_BREADY,
    input  logic [1:0]  M2S_AXI_BRESP,

    input  logic        wr_frame_valid,
    output logic        wr_frame_ready,
    input  logic [31:0] wr_BUF_ADDR,
    input  logic [31:0] wr_FRAME_BYTES,
    output logic        wr_frame_done,
    output logic        wr_error,

    input  logic        din_burst_valid,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [63:0] din,

    output logic [1:0]  debug_astate
);

    dram_state_e             state_q;
    logic                    awvalid_q;
    logic [31:0]             awaddr_q;
    logic [31-BURST_SHIFT:0] bursts_left_q;
    logic [3:0]              beat_cnt_q;
    logic                    data_done_q;
    logic                    done_q;
    logic                    error_q;

    logic                    w_data_phase;
    logic                    w_wfire;
    logic [31-BURST_SHIFT:0] w_frame_bursts;
    logic                    w_unused_bytes;

    // Sub-burst remainder bytes are never written; a zero-length frame still
    // produces one burst.
    assign w_frame_bursts = (wr_FRAME_BYTES[31:BURST_SHIFT] == '0)
                          ? (32-BURST_SHIFT)'(1)
                          : wr_FRAME_BYTES[31:BURST_SHIFT];
    assign w_unused_bytes = ^wr_FRAME_BYTES[BURST_SHIFT-1:0];

    assign w_data_phase = (state_q == ST_DATA_RESP) && !data_done_q;
    assign w_wfire      = M2S_AXI_WVALID && M2S_AXI_WREADY;

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            awvalid_q     <= 1'b0;
            awaddr_q      <= 32'h0;
            bursts_left_q <= '0;
            beat_cnt_q    <= 4'h0;
            data_done_q   <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (wr_frame_valid) begin
                        awaddr_q      <= wr_BUF_ADDR;
                        bursts_left_q <= w_frame_bursts;
                        error_q       <= 1'b0;
                        state_q       <= ST_FRAME_IDLE;
                    end
                end
                ST_FRAME_IDLE: begin
                    if (din_burst_valid) begin
                        awvalid_q <= 1'b1;
                        state_q   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (M2S_AXI_AWREADY) begin
                        awvalid_q   <= 1'b0;
                        beat_cnt_q  <= AXI_LEN;
                        data_done_q <= 1'b0;
                        state_q     <= ST_DATA_RESP;
                    end
                end
                ST_DATA_RESP: begin
                    if (!data_done_q) begin
                        if (w_wfire) begin
                            beat_cnt_q <= beat_cnt_q - 4'd1;
                            if (beat_cnt_q == 4'd0) begin
                                data_done_q <= 1'b1;
                            end
                        end
                    end else if (M2S_AXI_BVALID) begin
                        if (M2S_AXI_BRESP != 2'b00) begin
                            error_q <= 1'b1;
                        end
                        awaddr_q      <= awaddr_q + 32'(BURST_BYTES);
                        bursts_left_q <= bursts_left_q - 1'b1;
                        if (bursts_left_q == (32-BURST_SHIFT)'(1)) begin
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_FRAME_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign M2S_AXI_ACLK    = fclk;
    assign M2S_AXI_AWVALID = awvalid_q;
    assign M2S_AXI_AWADDR  = awaddr_q;
    assign M2S_AXI_AWBURST = AXI_BURST;
    assign M2S_AXI_AWLEN   = AXI_LEN;
    assign M2S_AXI_AWSIZE  = AXI_SIZE;

    // Data path is a pure pass-through; the FIFO sees WREADY only in the data phase.
    assign M2S_AXI_WVALID  = w_data_phase && din_valid;
    assign din_ready       = w_data_phase && M2S_AXI_WREADY;
    assign M2S_AXI_WDATA   = din;
    assign M2S_AXI_WSTRB   = AXI_WSTRB;
    assign M2S_AXI_WLAST   = w_data_phase && (beat_cnt_q == 4'd0);
    assign M2S_AXI_BREADY  = (state_q == ST_DATA_RESP) && data_done_q;

    assign wr_frame_ready  = (state_q == ST_IDLE);
    assign wr_frame_done   = done_q;
    assign wr_error        = error_q;
    assign debug_astate    = state_q;

endmodule
`default_nettype wire
